bit_scan_encoder: RTL



---
 rtl/bit_scan_encoder_pkg.sv | 17 +
 rtl/bit_scan_encoder_prio_enc.sv | 34 +++
 rtl/bit_scan_encoder.sv | 92 +++++++++
 3 files changed

// File: rtl/bit_scan_encoder_pkg.sv
// Shared types and helpers for the bit scan encoder: the 1-bit scan state
// encoding and a constant-evaluable clog2 used to size index ports.
package bit_scan_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bit_scan_encoder_prio_enc.sv
// Combinational W-to-IDXW priority encoder. MSB_FIRST selects whether the
// highest or the lowest set bit wins; none flags an all-zero input.
module prio_enc #(
  parameter int W         = 8,
  parameter int IDXW      = 3,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [W-1:0]    vec,
  output logic [IDXW-1:0] idx,
  output logic            none
);

  // Later hits overwrite earlier ones, so the loop direction picks the winner.
  always_comb begin
    idx  = '0;
    none = 1'b1;
    if (MSB_FIRST) begin
      for (int i = 0; i < W; i++) begin
        if (vec[i]) begin
          idx  = IDXW'(i);
          none = 1'b0;
        end
      end
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        if (vec[i]) begin
          idx  = IDXW'(i);
          none = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/bit_scan_encoder.sv
// Sequential bit scan encoder: accepts a W-bit vector and emits the index of
// each set bit, one per output handshake, in priority order.
module bit_scan_encoder
  import bit_scan_encoder_pkg::*;
#(
  parameter int W         = 8,
  parameter int IDXW      = clog2(W),
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] out_idx,
  output logic            out_last,
  output logic            zero_pulse,
  output logic [IDXW:0]   bit_cnt
);

  state_t          state;
  logic [W-1:0]    pending;
  logic [IDXW-1:0] enc_idx;
  logic            enc_none;
  logic            is_last;
  logic [W-1:0]    clear_mask;

  function automatic logic [IDXW:0] popcount(input logic [W-1:0] v);
    logic [IDXW:0] cnt;
    cnt = '0;
    for (int i = 0; i < W; i++) cnt = cnt + (IDXW + 1)'(v[i]);
    return cnt;
  endfunction

  prio_enc #(
    .W         (W),
    .IDXW      (IDXW),
    .MSB_FIRST (MSB_FIRST)
  ) u_prio_enc (
    .vec  (pending),
    .idx  (enc_idx),
    .none (enc_none)
  );

  // A single remaining bit means the current index closes out the vector.
  assign is_last    = !enc_none && ((pending & (pending - W'(1))) == '0);
  assign clear_mask = W'(1) << enc_idx;

  assign in_ready  = rst_n && en && (state == IDLE);
  assign out_valid = (state == SCAN);
  assign out_idx   = out_valid ? enc_idx : '0;
  assign out_last  = out_valid && is_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      zero_pulse <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      zero_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && en) begin
            if (in_vec != '0) begin
              pending <= in_vec;
              bit_cnt <= popcount(in_vec);
              state   <= SCAN;
            end else begin
              zero_pulse <= 1'b1;
              bit_cnt    <= '0;
            end
          end
        end
        SCAN: begin
          // Dropping en abandons the rest of the vector; bit_cnt is kept.
          if (!en) begin
            pending <= '0;
            state   <= IDLE;
          end else if (out_ready) begin
            pending <= pending & ~clear_mask;
            if (is_last) state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
